// File: rtl/seqlink_pkg.sv
// +----------------------------------------------------------------------------+
// | seqlink_pkg                                                                |
// | Shared definitions for the 0110 serial-pattern link (source and sink side).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package seqlink_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_SEND = c_ST_SEND,
        ST_GAP  = c_ST_GAP
    } state_t;

    localparam int         c_PAT_W      = 4;
    localparam logic [3:0] c_PATTERN    = 4'b0110;
    localparam logic       c_IDLE_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pattern_shifter.sv
// +----------------------------------------------------------------------------+
// | pattern_shifter                                                            |
// | Parallel-load, MSB-first shift register; vacated bits fill with idle level.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pattern_shifter
    import seqlink_pkg::*;
#(
    parameter int               PAT_W   = c_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = c_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_shift,
    input  logic i_clear,
    output logic o_sout
);

    logic [PAT_W-1:0] r_q;

    // Filling with the idle level means the line returns high by itself once
    // the last pattern bit has been shifted out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= {PAT_W{c_IDLE_LEVEL}};
        end else if (i_clear) begin
            r_q <= {PAT_W{c_IDLE_LEVEL}};
        end else if (i_load) begin
            r_q <= PATTERN;
        end else if (i_shift) begin
            r_q <= {r_q[PAT_W-2:0], c_IDLE_LEVEL};
        end
    end

    assign o_sout = r_q[PAT_W-1];

endmodule

`default_nettype wire

// File: rtl/sequence_gen.sv
// +----------------------------------------------------------------------------+
// | sequence_gen                                                               |
// | Serial pattern transmitter: repeats PATTERN rep_cnt times with idle gaps.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sequence_gen
    import seqlink_pkg::*;
#(
    parameter int               PAT_W   = c_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = c_PATTERN,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             x,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(PAT_W - 1);

    state_t           r_state,     w_state_nxt;
    logic [IDX_W-1:0] r_bit_idx,   w_bit_idx_nxt;
    logic [CNT_W-1:0] r_rep,       w_rep_nxt;
    logic [GAP_W-1:0] r_gap_len,   w_gap_len_nxt;
    logic [GAP_W-1:0] r_gap_cnt,   w_gap_cnt_nxt;
    logic             r_bit_valid, w_bit_valid_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;
    logic             w_load;
    logic             w_shift;
    logic             w_clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_idx   <= '0;
            r_rep       <= '0;
            r_gap_len   <= '0;
            r_gap_cnt   <= '0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_rep       <= w_rep_nxt;
            r_gap_len   <= w_gap_len_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Output flags are computed for the upcoming state so they line up with
    // the shifter MSB, which is itself the registered line driver.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_idx_nxt   = r_bit_idx;
        w_rep_nxt       = r_rep;
        w_gap_len_nxt   = r_gap_len;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_bit_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        w_clear         = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start && (rep_cnt != '0)) begin
                    w_state_nxt     = ST_SEND;
                    w_load          = 1'b1;
                    w_rep_nxt       = rep_cnt;
                    w_gap_len_nxt   = gap;
                    w_bit_idx_nxt   = c_LAST_IDX;
                    w_bit_valid_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                end
            end

            ST_SEND: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end else if (r_bit_idx != '0) begin
                    w_shift         = 1'b1;
                    w_bit_idx_nxt   = r_bit_idx - IDX_W'(1);
                    w_bit_valid_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                end else if (r_rep != CNT_W'(1)) begin
                    // Ending on 1 rather than 0 lets the all-ones count run
                    // to completion without wrapping.
                    w_rep_nxt = r_rep - CNT_W'(1);
                    if (r_gap_len != '0) begin
                        w_state_nxt   = ST_GAP;
                        w_shift       = 1'b1;
                        w_gap_cnt_nxt = r_gap_len;
                        w_busy_nxt    = 1'b1;
                    end else begin
                        w_load          = 1'b1;
                        w_bit_idx_nxt   = c_LAST_IDX;
                        w_bit_valid_nxt = 1'b1;
                        w_busy_nxt      = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_shift     = 1'b1;
                    w_rep_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end
            end

            ST_GAP: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end else if (r_gap_cnt == GAP_W'(1)) begin
                    w_state_nxt     = ST_SEND;
                    w_load          = 1'b1;
                    w_gap_cnt_nxt   = '0;
                    w_bit_idx_nxt   = c_LAST_IDX;
                    w_bit_valid_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                    w_busy_nxt    = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_clear     = 1'b1;
            end
        endcase
    end

    pattern_shifter #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .o_sout  (x)
    );

    assign bit_valid = r_bit_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sequence_gen.sv
// +----------------------------------------------------------------------------+
// | tb_sequence_gen                                                            |
// | Self-checking bench: per-cycle queue model plus directed literal checks.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sequence_gen;

    localparam int         PAT_W   = 4;
    localparam logic [3:0] PATTERN = 4'b0110;
    localparam int         CNT_W   = 8;
    localparam int         GAP_W   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             x;
    logic             bit_valid;
    logic             busy;
    logic             done;

    sequence_gen #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rep_cnt   (rep_cnt),
        .gap       (gap),
        .abort     (abort),
        .x         (x),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected outputs for each cycle, built whole when a burst is accepted.
    typedef struct packed {
        logic x;
        logic bv;
        logic busy;
        logic done;
    } exp_t;

    localparam exp_t IDLE_EXP = '{x: 1'b1, bv: 1'b0, busy: 1'b0, done: 1'b0};

    exp_t exp_q[$];
    exp_t cur = IDLE_EXP;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            cur = IDLE_EXP;
        end else if (cur.busy && abort) begin
            exp_q.delete();
            cur = IDLE_EXP;
        end else if (!cur.busy && start && (rep_cnt != 0)) begin
            exp_q.delete();
            for (int r = 0; r < int'(rep_cnt); r++) begin
                for (int i = 0; i < PAT_W; i++)
                    exp_q.push_back('{x: PATTERN[PAT_W-1-i], bv: 1'b1, busy: 1'b1, done: 1'b0});
                if (r < int'(rep_cnt) - 1)
                    for (int g = 0; g < int'(gap); g++)
                        exp_q.push_back('{x: 1'b1, bv: 1'b0, busy: 1'b1, done: 1'b0});
            end
            exp_q.push_back('{x: 1'b1, bv: 1'b0, busy: 1'b0, done: 1'b1});
            cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = IDLE_EXP;
        end
    end

    // Observed-activity counters and a reference 0110 detector on the line.
    int         busy_cnt = 0;
    int         bv_cnt   = 0;
    int         done_cnt = 0;
    int         det_cnt  = 0;
    logic [3:0] det_sr   = 4'hF;

    always @(negedge clk) begin
        check("x", 32'(x), 32'(cur.x));
        check("bit_valid", 32'(bit_valid), 32'(cur.bv));
        check("busy", 32'(busy), 32'(cur.busy));
        check("done", 32'(done), 32'(cur.done));
        busy_cnt += int'(busy);
        bv_cnt   += int'(bit_valid);
        done_cnt += int'(done);
        det_sr    = {det_sr[2:0], x};
        if (det_sr == 4'b0110) det_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int r, input int g);
        rep_cnt = CNT_W'(r);
        gap     = GAP_W'(g);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    int         b0, v0, d0, z0;
    logic [5:0] xcap;

    task automatic snap();
        b0 = busy_cnt; v0 = bv_cnt; d0 = done_cnt; z0 = det_cnt;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rep_cnt = '0; gap = '0; abort = 1'b0;
        cycles(3);
        check("reset_x", 32'(x), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        cycles(2);

        // Single repetition, line captured from the start cycle onwards.
        snap();
        rep_cnt = 8'd1; gap = 4'd0; start = 1'b1;
        xcap = '0;
        for (int i = 0; i < 6; i++) begin
            xcap = {xcap[4:0], x};
            @(negedge clk);
            start = 1'b0;
        end
        check("t1_xseq", 32'(xcap), 32'b101101);
        check("t1_bv", 32'(bv_cnt - v0), 32'd4);
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_det", 32'(det_cnt - z0), 32'd1);
        cycles(2);

        // Back-to-back repetitions.
        snap();
        pulse_start(3, 0);
        cycles(16);
        check("t2_busy", 32'(busy_cnt - b0), 32'd12);
        check("t2_det", 32'(det_cnt - z0), 32'd3);
        check("t2_done", 32'(done_cnt - d0), 32'd1);

        // Repetitions separated by a gap.
        snap();
        pulse_start(2, 3);
        cycles(15);
        check("t3_busy", 32'(busy_cnt - b0), 32'd11);
        check("t3_bv", 32'(bv_cnt - v0), 32'd8);
        check("t3_done", 32'(done_cnt - d0), 32'd1);
        check("t3_det", 32'(det_cnt - z0), 32'd2);

        // Ignored requests: zero count, then start and parameter changes mid-burst.
        snap();
        pulse_start(0, 2);
        cycles(3);
        check("t4_zero_busy", 32'(busy_cnt - b0), 32'd0);
        pulse_start(2, 1);
        cycles(2);
        pulse_start(5, 0);
        cycles(12);
        check("t4_busy", 32'(busy_cnt - b0), 32'd9);
        check("t4_done", 32'(done_cnt - d0), 32'd1);

        // Abort on the second bit of repetition 2 of 3.
        snap();
        pulse_start(3, 0);
        cycles(5);
        check("t5_bit1_x", 32'(x), 32'd1);
        check("t5_bit1_bv", 32'(bit_valid), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_x", 32'(x), 32'd1);
        check("t5_abort_busy", 32'(busy), 32'd0);
        cycles(10);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        snap();
        pulse_start(1, 0);
        cycles(6);
        check("t5_fresh_busy", 32'(busy_cnt - b0), 32'd4);
        check("t5_fresh_det", 32'(det_cnt - z0), 32'd1);

        // Asynchronous reset in the middle of a burst.
        snap();
        pulse_start(3, 2);
        cycles(2);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_x", 32'(x), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_bv", 32'(bit_valid), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        cycles(2);
        reset = 1'b0;
        cycles(1);
        snap();
        pulse_start(1, 0);
        cycles(6);
        check("t6_after_done", 32'(done_cnt - d0), 32'd1);
        check("t6_after_det", 32'(det_cnt - z0), 32'd1);
        check("t6_after_bv", 32'(bv_cnt - v0), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
